// File: rtl/ln_result_drain.sv
// ln_result_drain: 2-entry ping-pong result buffer streaming one element per cycle.
// Define LN_DRAIN_CHECKSUM_EN to add the per-vector checksum outputs csum/csum_valid.
module ln_result_drain #(
  parameter int LANES = 64,
  parameter int DW = 16,
  localparam int IW = $clog2(LANES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vec_valid,
  output logic                vec_ready,
  input  logic [LANES*DW-1:0] vec_data,
  output logic                elem_valid,
  input  logic                elem_ready,
  output logic [DW-1:0]       elem_data,
  output logic [IW-1:0]       elem_idx,
  output logic                elem_last,
  output logic [15:0]         vec_count
`ifdef LN_DRAIN_CHECKSUM_EN
  ,
  output logic [15:0]         csum,
  output logic                csum_valid
`endif
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;
  logic [DW-1:0] mem [2][LANES];
  logic wr_ptr, rd_ptr, push, hs, pop;
  logic [1:0] count, count_nx;
  assign vec_ready = count != 2'd2;
  assign push = vec_valid && vec_ready;
  assign hs = elem_valid && elem_ready;
  assign pop = hs && elem_last;
  assign count_nx = count + {1'b0, push} - {1'b0, pop};
  assign elem_last = elem_valid && elem_idx == IW'(LANES - 1);
  assign elem_data = elem_valid ? mem[rd_ptr][elem_idx] : '0;
  // Lanes are stored in emission order: the MSB lane lands at index 0.
  always_ff @(posedge clk)
    if (push)
      for (int i = 0; i < LANES; i++) mem[wr_ptr][i] <= vec_data[(LANES-1-i)*DW +: DW];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      elem_valid <= 1'b0;
      elem_idx <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= '0;
      vec_count <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      count <= count_nx;
      if (state == IDLE) begin
        if (count != 2'd0) begin
          state <= STREAM;
          elem_valid <= 1'b1;
          elem_idx <= '0;
        end
      end else if (hs) begin
        elem_idx <= elem_last ? '0 : elem_idx + 1'b1;
        if (elem_last) begin
          rd_ptr <= ~rd_ptr;
          vec_count <= vec_count + 16'd1;
          if (count_nx == 2'd0) begin
            state <= IDLE;
            elem_valid <= 1'b0;
          end
        end
      end
    end
`ifdef LN_DRAIN_CHECKSUM_EN
  logic [15:0] acc, sum;
  assign sum = acc + 16'(elem_data);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      csum <= '0;
      csum_valid <= 1'b0;
    end else begin
      csum_valid <= pop;
      if (pop) begin
        csum <= sum;
        acc <= '0;
      end else if (hs) acc <= sum;
    end
`endif
endmodule
